// File: rtl/alu_srcb_stage_if.sv
// Operand-B stage request/response bundle: selector plus sources in, registered operand out.
// The master modport is the producer/consumer side (control FSM plus ALU); slave is the stage.
interface alu_srcb_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       selector;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic [WIDTH-1:0] input_c;
  logic [IMM_W-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [2:0]       out_sel;

  modport master (
    output in_valid, selector, input_a, input_b, input_c, imm, out_ready,
    input  in_ready, out_valid, out, out_sel
  );

  modport slave (
    input  in_valid, selector, input_a, input_b, input_c, imm, out_ready,
    output in_ready, out_valid, out, out_sel
  );
endinterface

// File: rtl/alu_srcb_stage.sv
// Registered ALU operand-B selector with a 2-entry skid buffer (main + skid).
// Optional illegal-selector flag/counter enabled by defining ALU_SRCB_ILLEGAL_FLAG_EN.
module alu_srcb_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned CONST_1 = 1,
  parameter int unsigned CONST_2 = 4,
  parameter int unsigned SHIFT   = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  alu_srcb_stage_if.slave bus
`ifdef ALU_SRCB_ILLEGAL_FLAG_EN
  ,
  output logic       sel_err,
  output logic [7:0] sel_err_cnt
`endif
);

  typedef struct packed {
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t state_q;
  entry_t main_q, skid_q, dec_d;
  logic   out_valid_q, in_ready_q;
  logic   accept;

  logic signed [IMM_W-1:0] imm_s;
  logic        [WIDTH-1:0] imm_ext, imm_shl;

  assign imm_s   = $signed(bus.imm);
  assign imm_ext = WIDTH'(imm_s);
  assign imm_shl = imm_ext << SHIFT;

  // Decode is captured at accept time so later input changes never leak into buffered data.
  always_comb begin
    dec_d     = '0;
    dec_d.sel = bus.selector;
    unique case (bus.selector)
      3'b000:  dec_d.data = bus.input_a;
      3'b001:  dec_d.data = WIDTH'(CONST_1);
      3'b010:  dec_d.data = WIDTH'(CONST_2);
      3'b011:  dec_d.data = bus.input_b;
      3'b100:  dec_d.data = bus.input_c;
      3'b101:  dec_d.data = imm_ext;
      3'b110:  dec_d.data = imm_shl;
      default: dec_d.data = '0;
    endcase
  end

  assign accept = bus.in_valid && in_ready_q;

  // in_ready is a registered function of state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        S_EMPTY: if (accept) begin
          main_q      <= dec_d;
          state_q     <= S_ONE;
          out_valid_q <= 1'b1;
        end
        S_ONE: if (accept && !bus.out_ready) begin
          skid_q     <= dec_d;
          state_q    <= S_FULL;
          in_ready_q <= 1'b0;
        end else if (accept) begin
          main_q <= dec_d;
        end else if (bus.out_ready) begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
        end
        S_FULL: if (bus.out_ready) begin
          main_q     <= skid_q;
          state_q    <= S_ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = main_q.data;
  assign bus.out_sel   = main_q.sel;

`ifdef ALU_SRCB_ILLEGAL_FLAG_EN
  logic       ill_acc;
  logic       sel_err_q;
  logic [7:0] sel_err_cnt_q;

  // A flushed request is dropped, so it does not count as an illegal accept.
  assign ill_acc = accept && !flush && (bus.selector == 3'b111);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_q     <= 1'b0;
      sel_err_cnt_q <= '0;
    end else if (ill_acc) begin
      sel_err_q <= 1'b1;
      if (sel_err_cnt_q != 8'hFF) sel_err_cnt_q <= sel_err_cnt_q + 8'd1;
    end
  end

  assign sel_err     = sel_err_q;
  assign sel_err_cnt = sel_err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Directed bench for alu_srcb_stage: reset, decode, skid/backpressure, flush, async reset,
// and the illegal-selector flag when ALU_SRCB_ILLEGAL_FLAG_EN is defined.
module tb_alu_srcb_stage;
  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  alu_srcb_stage_if #(.WIDTH(32), .IMM_W(16)) bus ();

`ifdef ALU_SRCB_ILLEGAL_FLAG_EN
  logic       sel_err;
  logic [7:0] sel_err_cnt;
`endif

  alu_srcb_stage #(.WIDTH(32), .IMM_W(16), .CONST_1(1), .CONST_2(4), .SHIFT(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
`ifdef ALU_SRCB_ILLEGAL_FLAG_EN
    ,
    .sel_err     (sel_err),
    .sel_err_cnt (sel_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [15:0] im);
    bus.in_valid = 1'b1;
    bus.selector = sel;
    bus.input_a  = a;
    bus.input_b  = b;
    bus.input_c  = c;
    bus.imm      = im;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    bus.out_ready = 1'b1;
    drive(3'b000, 32'h12345678, 32'h0, 32'h0, 16'h0);
    #12;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out !== 32'h0) $display("FAIL reset_out got %h exp 00000000", bus.out); else pass_cnt++;
    total_cnt++; if (bus.out_sel !== 3'b000) $display("FAIL reset_out_sel got %b exp 000", bus.out_sel); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL first_valid got %b exp 1", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out !== 32'h12345678) $display("FAIL first_out got %h exp 12345678", bus.out); else pass_cnt++;
    total_cnt++; if (bus.out_sel !== 3'b000) $display("FAIL first_sel got %b exp 000", bus.out_sel); else pass_cnt++;
  endtask

  task automatic test_const_imm();
    logic [2:0]  sels [4] = '{3'b001, 3'b010, 3'b101, 3'b110};
    logic [31:0] exps [4] = '{32'h00000001, 32'h00000004, 32'hFFFF8001, 32'hFFFE0004};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(sels[i], 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'h8001);
      step();
      total_cnt++; if (bus.out !== exps[i] || bus.out_valid !== 1'b1)
        $display("FAIL const_imm_%0d got %h/%b exp %h/1", i, bus.out, bus.out_valid, exps[i]); else pass_cnt++;
      total_cnt++; if (bus.out_sel !== sels[i]) $display("FAIL const_sel_%0d got %b exp %b", i, bus.out_sel, sels[i]); else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL const_drain got %b exp 0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_reserved();
    bus.out_ready = 1'b1;
    drive(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF);
    step();
    total_cnt++; if (bus.out !== 32'h0) $display("FAIL reserved_out got %h exp 00000000", bus.out); else pass_cnt++;
    total_cnt++; if (bus.out_sel !== 3'b111) $display("FAIL reserved_sel got %b exp 111", bus.out_sel); else pass_cnt++;
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(3'b011, 32'h0, 32'hA, 32'h0, 16'h0);
    step();
    total_cnt++; if (bus.out !== 32'hA) $display("FAIL bp_first got %h exp 0000000a", bus.out); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_one got %b exp 1", bus.in_ready); else pass_cnt++;
    drive(3'b100, 32'h0, 32'h0, 32'hB, 16'h0);
    step();
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_full got %b exp 0", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out !== 32'hA || bus.out_sel !== 3'b011) $display("FAIL bp_hold got %h/%b exp 0000000a/011", bus.out, bus.out_sel); else pass_cnt++;
    bus.in_valid = 1'b0;
    step();
    total_cnt++; if (bus.out !== 32'hA || bus.out_valid !== 1'b1) $display("FAIL bp_stable got %h/%b exp 0000000a/1", bus.out, bus.out_valid); else pass_cnt++;
    bus.out_ready = 1'b1;
    step();
    total_cnt++; if (bus.out !== 32'hB || bus.out_sel !== 3'b100) $display("FAIL bp_second got %h/%b exp 0000000b/100", bus.out, bus.out_sel); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", bus.in_ready); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(3'b000, 32'h11, 32'h0, 32'h0, 16'h0);
    step();
    drive(3'b000, 32'h22, 32'h0, 32'h0, 16'h0);
    step();
    drive(3'b000, 32'h33, 32'h0, 32'h0, 16'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL flush_full_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL flush_full_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out !== 32'h11) $display("FAIL flush_out_kept got %h exp 00000011", bus.out); else pass_cnt++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL flush_quiet_%0d got %b exp 0", i, bus.out_valid); else pass_cnt++;
    end
    bus.out_ready = 1'b0;
    drive(3'b000, 32'h44, 32'h0, 32'h0, 16'h0);
    step();
    drive(3'b000, 32'h55, 32'h0, 32'h0, 16'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.out !== 32'h44)
      $display("FAIL flush_one_accept got %h/%b exp 00000044/0", bus.out, bus.out_valid); else pass_cnt++;
    bus.out_ready = 1'b1;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL flush_dropped got %b exp 0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(3'b011, 32'h0, 32'h77, 32'h0, 16'h0);
    step();
    drive(3'b100, 32'h0, 32'h0, 32'h88, 16'h0);
    step();
    bus.in_valid = 1'b0;
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL async_pre_full got %b exp 0", bus.in_ready); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL async_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out !== 32'h0 || bus.out_sel !== 3'b000) $display("FAIL async_out got %h/%b exp 00000000/000", bus.out, bus.out_sel); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL async_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL async_after got %b exp 0", bus.out_valid); else pass_cnt++;
  endtask

`ifdef ALU_SRCB_ILLEGAL_FLAG_EN
  task automatic test_illegal_flag();
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    total_cnt++; if (sel_err !== 1'b0 || sel_err_cnt !== 8'd0) $display("FAIL flag_reset got %b/%0d exp 0/0", sel_err, sel_err_cnt); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(3'b111, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 16'h7FFF);
      step();
      total_cnt++; if (bus.out !== 32'h0) $display("FAIL flag_out_%0d got %h exp 00000000", i, bus.out); else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    step();
    total_cnt++; if (sel_err !== 1'b1) $display("FAIL flag_sticky got %b exp 1", sel_err); else pass_cnt++;
    total_cnt++; if (sel_err_cnt !== 8'd3) $display("FAIL flag_cnt3 got %0d exp 3", sel_err_cnt); else pass_cnt++;
    drive(3'b111, 32'h0, 32'h0, 32'h0, 16'h0);
    repeat (300) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    step();
    total_cnt++; if (sel_err_cnt !== 8'd255) $display("FAIL flag_sat got %0d exp 255", sel_err_cnt); else pass_cnt++;
    total_cnt++; if (sel_err !== 1'b1) $display("FAIL flag_sticky_end got %b exp 1", sel_err); else pass_cnt++;
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.selector  = 3'b000;
    bus.input_a   = '0;
    bus.input_b   = '0;
    bus.input_c   = '0;
    bus.imm       = '0;
    test_reset();
    test_const_imm();
    test_reserved();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef ALU_SRCB_ILLEGAL_FLAG_EN
    test_illegal_flag();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
